// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG run-length symbol front-end.
// ZZ maps zigzag position to the column-major stored coefficient index.
package jpeg_pkg;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned AMP_W  = 11;
  localparam int unsigned CAT_W  = AMP_W + 1;
  localparam logic [3:0]  ZRL_RUN = 4'd15;

  localparam logic signed [COEF_W-1:0] SAT_HI = 16'sd2047;
  localparam logic signed [COEF_W-1:0] SAT_LO = -16'sd2047;

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, ZRL, EOB, DONE} rle_state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17,
    6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
    6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20,
    6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
    6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36,
    6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
    6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
  };

  // Clamp a signed 16-bit value into the symmetric range +/-2047.
  function automatic logic signed [CAT_W-1:0] sat_amp(input logic signed [COEF_W-1:0] v);
    if (v > SAT_HI) return CAT_W'(SAT_HI);
    if (v < SAT_LO) return CAT_W'(SAT_LO);
    return CAT_W'(v);
  endfunction

endpackage

// File: rtl/jpeg_rle_cat.sv
// Magnitude category and JPEG amplitude bits for a 12-bit signed value.
// The one unrepresentable code (-2048) is pulled in to -2047.
module jpeg_rle_cat
  import jpeg_pkg::*;
(
  input  logic signed [CAT_W-1:0] value,
  output logic [3:0]              size,
  output logic [AMP_W-1:0]        amp
);

  localparam logic signed [CAT_W-1:0] MOST_NEG = {1'b1, {AMP_W{1'b0}}};
  localparam logic signed [CAT_W-1:0] ONE      = CAT_W'(1);

  logic signed [CAT_W-1:0] v_sat;
  logic [AMP_W-1:0]        mag;
  logic [AMP_W-1:0]        mask;
  logic [AMP_W-1:0]        neg_bits;

  always_comb begin
    v_sat = (value == MOST_NEG) ? -CAT_W'(2047) : value;
    mag   = v_sat[CAT_W-1] ? AMP_W'(-v_sat) : v_sat[AMP_W-1:0];
    size  = 4'd0;
    for (int i = 0; i < int'(AMP_W); i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    mask     = AMP_W'((CAT_W'(1) << size) - CAT_W'(1));
    neg_bits = AMP_W'(v_sat - ONE);
    amp      = v_sat[CAT_W-1] ? (neg_bits & mask) : v_sat[AMP_W-1:0];
  end

endmodule

// File: rtl/jpeg_rle.sv
// Reads one zigzag-ordered 8x8 block from the quantiser RAM and emits
// DC-differential, AC run/size/amplitude, ZRL and EOB symbols over valid/ready.
module jpeg_rle
  import jpeg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dc_clr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0]       mem_adr_o,
  input  logic [31:0]      mem_dat_i,
  output logic             sym_valid_o,
  input  logic             sym_ready_i,
  output logic             sym_dc_o,
  output logic [3:0]       sym_run_o,
  output logic [3:0]       sym_size_o,
  output logic [AMP_W-1:0] sym_amp_o
);

  rle_state_t state;
  logic [5:0] k;
  logic [5:0] run;
  logic [5:0] run_left;
  logic [5:0] k_nxt;

  logic signed [CAT_W-1:0]  prev_dc;
  logic signed [CAT_W-1:0]  pend;
  logic signed [COEF_W-1:0] raw;
  logic signed [CAT_W-1:0]  coef;
  logic signed [CAT_W:0]    diff13;
  logic signed [CAT_W-1:0]  dc_diff;
  logic signed [CAT_W-1:0]  cat_in;
  logic [3:0]               cat_size;
  logic [AMP_W-1:0]         cat_amp;

  // Coefficient select, DC differential and category source.
  always_comb begin
    raw      = ZZ[k][0] ? mem_dat_i[31:16] : mem_dat_i[15:0];
    coef     = sat_amp(raw);
    diff13   = {coef[CAT_W-1], coef} - {prev_dc[CAT_W-1], prev_dc};
    dc_diff  = sat_amp(COEF_W'(diff13));
    cat_in   = (state != EVAL) ? pend : ((k == 6'd0) ? dc_diff : coef);
    run_left = run - 6'd16;
    k_nxt    = k + 6'd1;
  end

  jpeg_rle_cat u_cat (
    .value (cat_in),
    .size  (cat_size),
    .amp   (cat_amp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      k           <= '0;
      run         <= '0;
      prev_dc     <= '0;
      pend        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_adr_o   <= '0;
      sym_valid_o <= 1'b0;
      sym_dc_o    <= 1'b0;
      sym_run_o   <= '0;
      sym_size_o  <= '0;
      sym_amp_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dc_clr_i) prev_dc <= '0;
          if (start_i) begin
            k         <= '0;
            run       <= '0;
            mem_adr_o <= ZZ[0][5:1];
            busy_o    <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= EVAL;
        EVAL: begin
          pend <= coef;
          if (k == 6'd0) begin
            prev_dc     <= coef;
            sym_valid_o <= 1'b1;
            sym_dc_o    <= 1'b1;
            sym_run_o   <= '0;
            sym_size_o  <= cat_size;
            sym_amp_o   <= cat_amp;
            state       <= EMIT;
          end else if (coef == '0) begin
            run <= run + 6'd1;
            if (k == 6'd63) begin
              sym_valid_o <= 1'b1;
              sym_dc_o    <= 1'b0;
              sym_run_o   <= '0;
              sym_size_o  <= '0;
              sym_amp_o   <= '0;
              state       <= EOB;
            end else begin
              k         <= k_nxt;
              mem_adr_o <= ZZ[k_nxt][5:1];
              state     <= FETCH;
            end
          end else if (run >= 6'd16) begin
            sym_valid_o <= 1'b1;
            sym_dc_o    <= 1'b0;
            sym_run_o   <= ZRL_RUN;
            sym_size_o  <= '0;
            sym_amp_o   <= '0;
            state       <= ZRL;
          end else begin
            sym_valid_o <= 1'b1;
            sym_dc_o    <= 1'b0;
            sym_run_o   <= run[3:0];
            sym_size_o  <= cat_size;
            sym_amp_o   <= cat_amp;
            state       <= EMIT;
          end
        end
        // Held nonzero coefficient is in pend; swap to it once runs drop below 16.
        ZRL: begin
          if (sym_ready_i) begin
            run <= run_left;
            if (run_left < 6'd16) begin
              sym_run_o  <= run_left[3:0];
              sym_size_o <= cat_size;
              sym_amp_o  <= cat_amp;
              state      <= EMIT;
            end
          end
        end
        EMIT: begin
          if (sym_ready_i) begin
            sym_valid_o <= 1'b0;
            sym_dc_o    <= 1'b0;
            sym_run_o   <= '0;
            sym_size_o  <= '0;
            sym_amp_o   <= '0;
            run         <= '0;
            if (k == 6'd63) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              k         <= k_nxt;
              mem_adr_o <= ZZ[k_nxt][5:1];
              state     <= FETCH;
            end
          end
        end
        EOB: begin
          if (sym_ready_i) begin
            sym_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_rle.sv
// Bench for jpeg_rle: scoreboarded symbol stream against directed vectors,
// a reference model on random blocks, back-pressure, reset and busy-time inputs.
module tb_jpeg_rle;

  typedef struct {
    int dc;
    int run;
    int size;
    int amp;
  } sym_t;

  typedef struct {
    int dc_val;
    int pos;
    int val;
    int dc_size;
    int dc_amp;
    int zrl;
    int run;
    int size;
    int amp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dc_clr;
  logic        busy;
  logic        done;
  logic [4:0]  mem_adr;
  logic [31:0] mem_dat;
  logic        sym_valid;
  logic        sym_ready;
  logic        sym_dc;
  logic [3:0]  sym_run;
  logic [3:0]  sym_size;
  logic [10:0] sym_amp;

  logic [31:0] ram [32];
  logic [15:0] blk [64];
  int          zz_st [64];
  sym_t        exp_q [$];
  int          n_chk;
  int          n_fail;
  int          bp_pct;
  int          model_prev;
  bit          hold_pending;
  sym_t        held;

  jpeg_rle dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .dc_clr_i    (dc_clr),
    .busy_o      (busy),
    .done_o      (done),
    .mem_adr_o   (mem_adr),
    .mem_dat_i   (mem_dat),
    .sym_valid_o (sym_valid),
    .sym_ready_i (sym_ready),
    .sym_dc_o    (sym_dc),
    .sym_run_o   (sym_run),
    .sym_size_o  (sym_size),
    .sym_amp_o   (sym_amp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  always @(posedge clk) mem_dat <= ram[mem_adr];

  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 sym_ready = ($urandom_range(0, 99) >= bp_pct);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Symbol scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        n_chk++;
        if (!(sym_valid && int'(sym_dc) == held.dc && int'(sym_run) == held.run &&
              int'(sym_size) == held.size && int'(sym_amp) == held.amp)) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%0d dc=%0d run=%0d size=%0d amp=%0d, expected v=1 dc=%0d run=%0d size=%0d amp=%0d",
                   sym_valid, sym_dc, sym_run, sym_size, sym_amp, held.dc, held.run, held.size, held.amp);
        end
      end
      if (sym_valid && sym_ready) begin
        hold_pending = 1'b0;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_sym: got dc=%0d run=%0d size=%0d amp=%0d, expected no symbol",
                   sym_dc, sym_run, sym_size, sym_amp);
        end else begin
          sym_t e;
          e = exp_q.pop_front();
          if (!(int'(sym_dc) == e.dc && int'(sym_run) == e.run &&
                int'(sym_size) == e.size && int'(sym_amp) == e.amp)) begin
            n_fail++;
            $display("FAIL symbol: got dc=%0d run=%0d size=%0d amp=%0d, expected dc=%0d run=%0d size=%0d amp=%0d",
                     sym_dc, sym_run, sym_size, sym_amp, e.dc, e.run, e.size, e.amp);
          end
        end
      end else if (sym_valid) begin
        hold_pending = 1'b1;
        held.dc   = int'(sym_dc);
        held.run  = int'(sym_run);
        held.size = int'(sym_size);
        held.amp  = int'(sym_amp);
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  function automatic void build_zz();
    int idx;
    int lo;
    int hi;
    int r;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      for (int j = 0; j <= hi - lo; j++) begin
        r = (s % 2 == 0) ? hi - j : lo + j;
        zz_st[idx] = (s - r) * 8 + r;
        idx++;
      end
    end
  endfunction

  function automatic void load_block();
    int s;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    for (int i = 0; i < 64; i++) begin
      s = zz_st[i];
      if (s % 2 == 1) ram[s / 2][31:16] = blk[i];
      else            ram[s / 2][15:0]  = blk[i];
    end
  endfunction

  function automatic void clear_block();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endfunction

  function automatic void push(input int dc, input int run, input int size, input int amp);
    sym_t s;
    s.dc = dc; s.run = run; s.size = size; s.amp = amp;
    exp_q.push_back(s);
  endfunction

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2047) return -2047;
    return v;
  endfunction

  function automatic int bitlen(input int v);
    int m;
    int n;
    m = (v < 0) ? -v : v;
    n = 0;
    while (m > 0) begin
      n++;
      m = m >> 1;
    end
    return n;
  endfunction

  function automatic int ampl(input int v);
    if (v >= 0) return v;
    return (v - 1) & ((1 << bitlen(v)) - 1);
  endfunction

  // Reference symbol stream for the block currently in blk[].
  function automatic void model_block();
    int c;
    int d;
    int run;
    c = sat(int'($signed(blk[0])));
    d = sat(c - model_prev);
    push(1, 0, bitlen(d), ampl(d));
    model_prev = c;
    run = 0;
    for (int i = 1; i < 64; i++) begin
      c = sat(int'($signed(blk[i])));
      if (c == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          push(0, 15, 0, 0);
          run -= 16;
        end
        push(0, run, bitlen(c), ampl(c));
        run = 0;
      end
    end
    if (sat(int'($signed(blk[63]))) == 0) push(0, 0, 0, 0);
  endfunction

  task automatic run_block(input bit clr, input bit chk_cycles, input bit mid_pulse);
    int  nsym;
    int  n;
    bit  seen;
    load_block();
    nsym = exp_q.size();
    n = 0;
    seen = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    dc_clr = clr;
    while (n < 3000 && !seen) begin
      @(posedge clk);
      n++;
      #1 start = 1'b0;
      dc_clr = 1'b0;
      if (n == 1) check(busy == 1'b1, "busy_after_start", int'(busy), 1);
      if (mid_pulse && n == 40) begin
        start  = 1'b1;
        dc_clr = 1'b1;
      end
      seen = done;
    end
    check(seen, "done_timeout", n, 2 * 64 + nsym + 1);
    if (seen) begin
      if (chk_cycles) check(n == 2 * 64 + nsym + 1, "done_cycles", n, 2 * 64 + nsym + 1);
      check(busy == 1'b0, "busy_at_done", int'(busy), 0);
      @(posedge clk);
      #1 check(done == 1'b0, "done_one_cycle", int'(done), 0);
    end
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic int out_word();
    return int'({busy, done, sym_valid, mem_adr, sym_dc, sym_run, sym_size, sym_amp});
  endfunction

  vec_t vecs [10];

  initial begin
    vecs[0] = '{5,     1,  -1,     3,  5,    0, 0,  1,  0};
    vecs[1] = '{-5,    20, 7,      3,  2,    1, 3,  3,  7};
    vecs[2] = '{0,     63, 3000,   0,  0,    3, 14, 11, 2047};
    vecs[3] = '{2047,  5,  -2048,  11, 2047, 0, 4,  11, 0};
    vecs[4] = '{-2047, 17, 1024,   11, 0,    1, 0,  11, 1024};
    vecs[5] = '{1,     33, -3,     1,  1,    2, 0,  2,  0};
    vecs[6] = '{-32768, 2, 255,    11, 0,    0, 1,  8,  255};
    vecs[7] = '{100,   62, -100,   7,  100,  3, 13, 7,  27};
    vecs[8] = '{0,     16, 1,      0,  0,    0, 15, 1,  1};
    vecs[9] = '{0,     1,  32767,  0,  0,    0, 0,  11, 2047};

    n_chk = 0;
    n_fail = 0;
    bp_pct = 0;
    hold_pending = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    dc_clr = 1'b0;
    build_zz();
    clear_block();
    load_block();
    repeat (3) @(posedge clk);
    #1 check(out_word() == 0, "reset_outputs", out_word(), 0);
    rst = 1'b0;

    // All-zero block: DC size 0 then EOB, 131 cycles.
    clear_block();
    push(1, 0, 0, 0); push(0, 0, 0, 0);
    run_block(1'b1, 1'b1, 1'b0);

    // DC predictor chain including differential saturation.
    blk[0] = 16'sd5;     push(1, 0, 3, 5);     push(0, 0, 0, 0); run_block(1'b1, 1'b1, 1'b0);
    blk[0] = 16'sd3;     push(1, 0, 2, 1);     push(0, 0, 0, 0); run_block(1'b0, 1'b1, 1'b0);
    blk[0] = 16'sd2047;  push(1, 0, 11, 2044); push(0, 0, 0, 0); run_block(1'b0, 1'b1, 1'b0);
    blk[0] = -16'sd2047; push(1, 0, 11, 0);    push(0, 0, 0, 0); run_block(1'b0, 1'b1, 1'b0);

    // Two AC coefficients with an 18-zero gap.
    clear_block();
    blk[1] = -16'sd1;
    blk[20] = 16'sd7;
    push(1, 0, 0, 0); push(0, 0, 1, 0); push(0, 15, 0, 0); push(0, 2, 3, 7); push(0, 0, 0, 0);
    run_block(1'b1, 1'b1, 1'b0);

    // Directed single-AC vectors, predictor cleared each time.
    for (int v = 0; v < 10; v++) begin
      clear_block();
      blk[0] = 16'(vecs[v].dc_val);
      blk[vecs[v].pos] = 16'(vecs[v].val);
      push(1, 0, vecs[v].dc_size, vecs[v].dc_amp);
      for (int z = 0; z < vecs[v].zrl; z++) push(0, 15, 0, 0);
      push(0, vecs[v].run, vecs[v].size, vecs[v].amp);
      if (vecs[v].pos < 63) push(0, 0, 0, 0);
      run_block(1'b1, 1'b1, 1'b0);
    end

    // Random blocks: free-running consumer, then 30% back-pressure.
    for (int it = 0; it < 3; it++) begin
      clear_block();
      blk[0] = 16'($signed($urandom_range(0, 6000)) - 3000);
      for (int i = 1; i < 64; i++) begin
        if ($urandom_range(0, 99) < 20) blk[i] = 16'($signed($urandom_range(0, 8000)) - 4000);
      end
      bp_pct = 0;
      model_prev = 0;
      model_block();
      run_block(1'b1, 1'b1, 1'b0);
      bp_pct = 30;
      model_prev = 0;
      model_block();
      run_block(1'b1, 1'b0, 1'b0);
    end

    // Reset while a DC symbol is stalled.
    bp_pct = 100;
    clear_block();
    blk[0] = 16'sd9;
    blk[1] = 16'sd4;
    load_block();
    @(posedge clk);
    #1 start = 1'b1;
    begin
      bit got_valid;
      got_valid = 1'b0;
      for (int n = 0; n < 20 && !got_valid; n++) begin
        @(posedge clk);
        #1 start = 1'b0;
        got_valid = sym_valid;
      end
      check(got_valid, "stall_valid_seen", int'(got_valid), 1);
    end
    #2 rst = 1'b1;
    #1 check(out_word() == 0, "reset_mid_emit", out_word(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bp_pct = 0;

    // Predictor restarts at zero; start/dc_clr pulsed mid-block are ignored.
    clear_block();
    blk[0] = 16'sd5;
    blk[3] = -16'sd7;
    push(1, 0, 3, 5); push(0, 2, 3, 0); push(0, 0, 0, 0);
    run_block(1'b0, 1'b1, 1'b1);
    clear_block();
    blk[0] = 16'sd3;
    push(1, 0, 2, 1); push(0, 0, 0, 0);
    run_block(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
